// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers responses for decode.
// Optional decode-starvation counter enabled by defining IFU_STARVE_CNT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [3:0]  if_opcode,
  output logic [31:0] fetch_starve_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  fetch_entry_t     fifo_q [FIFO_DEPTH];
  logic [31:0]      ipc_q  [FIFO_DEPTH];

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] ipc_rd_q, ipc_rd_d, ipc_wr_q, ipc_wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic             grant;
  logic             pop;
  logic             rsp_live;
  logic             push;
  logic [SUM_W-1:0] budget_used;
  fetch_entry_t     head;

  // Slots already claimed by buffered, live and to-be-dropped words.
  assign budget_used = SUM_W'(count_q) + SUM_W'(outstanding_q) + SUM_W'(discard_q);

  assign imem_req  = rst_n && !redirect_valid && (budget_used < SUM_W'(FIFO_DEPTH));
  assign imem_addr = pc_q;

  assign grant    = imem_req && imem_gnt;
  assign if_valid = (count_q != '0);
  assign pop      = if_valid && if_ready;
  assign rsp_live = imem_rvalid && (discard_q == '0);
  assign push     = rsp_live && !redirect_valid;

  assign head      = fifo_q[rd_ptr_q];
  assign if_instr  = head.instr;
  assign if_pc     = head.pc;
  assign if_opcode = head.instr[31:28];

  always_comb begin
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    ipc_rd_d      = ipc_rd_q;
    ipc_wr_d      = ipc_wr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (redirect_valid) begin
      // Every live request becomes a response to drop; one may be landing right now.
      pc_d          = redirect_pc;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      ipc_rd_d      = '0;
      ipc_wr_d      = '0;
      count_d       = '0;
      outstanding_d = '0;
      discard_d     = discard_q + outstanding_q - CNT_W'(imem_rvalid);
    end else begin
      if (grant) begin
        pc_d     = pc_q + 32'd4;
        ipc_wr_d = ipc_wr_q + PTR_W'(1);
      end
      if (imem_rvalid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CNT_W'(1);
        end else begin
          ipc_rd_d = ipc_rd_q + PTR_W'(1);
        end
      end
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rsp_live);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      ipc_rd_q      <= '0;
      ipc_wr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      ipc_rd_q      <= ipc_rd_d;
      ipc_wr_q      <= ipc_wr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Payload storage: word FIFO written on accepted response, issue-pc queue on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
        ipc_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{pc: ipc_q[ipc_rd_q], instr: imem_rdata};
      end
      if (grant) begin
        ipc_q[ipc_wr_q] <= pc_q;
      end
    end
  end

`ifdef IFU_STARVE_CNT_EN
  logic [31:0] starve_q;

  // Saturating count of cycles decode was ready with nothing to take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (if_ready && !if_valid && (starve_q != 32'hFFFF_FFFF)) begin
      starve_q <= starve_q + 32'd1;
    end
  end

  assign fetch_starve_cnt = starve_q;
`else
  assign fetch_starve_cnt = '0;
`endif

endmodule
